ahb_master_ui_sequencer: RTL and testbench

//  Upstream command/data sequencer for the AHB master user interface. Accepts

---
 rtl/ahb_master_ui_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_ahb_master_ui_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_ui_sequencer.sv
// Burst command/data sequencer for an AHB master UI: buffers write data, issues beats on i_next, returns read beats.
// Latency: UI outputs follow FSM state, read data one cycle after i_rdav; write data stalls only when the FIFO is full.

module ahb_master_ui_sequencer_fifo #(
  parameter int WDT   = 32,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [WDT-1:0] push_dat,
  input  logic           pop,
  output logic [WDT-1:0] head,
  output logic           empty,
  output logic           full
);
  localparam int AW = $clog2(DEPTH);

  logic [WDT-1:0] mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic [AW:0]    count;
  logic           wr_en;
  logic           rd_en;

  // Full/empty come from registered pointers, so a pop never unblocks a push in the same cycle.
  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= push_dat;
  end

  assign head = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

module ahb_master_ui_sequencer #(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic                i_cmd_wr,
  input  logic [DATA_WDT-1:0] i_wdata,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic                i_next,
  output logic [DATA_WDT-1:0] o_data,
  output logic                o_dav,
  output logic [31:0]         o_addr,
  output logic [2:0]          o_size,
  output logic                o_wr,
  output logic                o_rd,
  output logic [BEAT_WDT-1:0] o_min_len,
  output logic                o_cont,
  input  logic [DATA_WDT-1:0] i_rdata,
  input  logic                i_rdav,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic                o_rdata_valid,
  output logic                o_busy,
  output logic                o_done
);
  typedef enum logic [2:0] {IDLE, FIRST, BURST, DRAIN, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         cmd_addr;
  logic [BEAT_WDT-1:0] cmd_len;
  logic [2:0]          cmd_size;
  logic                cmd_wr;
  logic [BEAT_WDT-1:0] issued;
  logic [BEAT_WDT-1:0] issued_inc;
  logic [BEAT_WDT-1:0] returned;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                accept;
  logic                beat_fire;
  logic                rd_take;

  assign accept     = i_cmd_valid & o_cmd_ready;
  assign beat_fire  = i_next & (o_rd | (o_wr & o_dav));
  assign issued_inc = issued + 1'b1;
  assign push       = i_wdata_valid & ~fifo_full;
  assign pop        = beat_fire & o_wr;
  assign rd_take    = i_rdav & ~cmd_wr & o_busy;

  assign o_wdata_ready = ~fifo_full;
  assign o_addr        = cmd_addr;
  assign o_size        = cmd_size;
  assign o_min_len     = cmd_len;

  ahb_master_ui_sequencer_fifo #(
    .WDT   (DATA_WDT),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk      (i_hclk),
    .rst_n    (i_hreset_n),
    .push     (push),
    .push_dat (i_wdata),
    .pop      (pop),
    .head     (o_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // FIRST/BURST only advance on a fired beat, which needs i_next, so UI outputs hold while i_next is low.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (i_cmd_len == '0) ? DONE : FIRST;
      FIRST,
      BURST: begin
        if (beat_fire) begin
          if (issued_inc == cmd_len) state_nxt = cmd_wr ? DONE : DRAIN;
          else                       state_nxt = BURST;
        end
      end
      DRAIN: if (returned == cmd_len) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_wr        = 1'b0;
    o_rd        = 1'b0;
    o_cont      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      IDLE:  o_cmd_ready = 1'b1;
      FIRST: begin
        o_busy = 1'b1;
        o_wr   = cmd_wr;
        o_rd   = ~cmd_wr;
      end
      BURST: begin
        o_busy = 1'b1;
        o_wr   = cmd_wr;
        o_rd   = ~cmd_wr;
        o_cont = 1'b1;
      end
      DRAIN: o_busy = 1'b1;
      DONE:  o_done = 1'b1;
      default: o_cmd_ready = 1'b0;
    endcase
    o_dav = o_wr & ~fifo_empty;
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) begin
      cmd_addr      <= '0;
      cmd_len       <= '0;
      cmd_size      <= '0;
      cmd_wr        <= 1'b0;
      issued        <= '0;
      returned      <= '0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
    end else begin
      o_rdata_valid <= rd_take;
      if (rd_take) o_rdata <= i_rdata;
      if (accept) begin
        cmd_addr <= i_cmd_addr;
        cmd_len  <= i_cmd_len;
        cmd_size <= i_cmd_size;
        cmd_wr   <= i_cmd_wr;
        issued   <= '0;
        returned <= '0;
      end else begin
        if (beat_fire) issued <= issued_inc;
        // Extra read beats past the burst length are passed through but not counted.
        if (rd_take && returned != cmd_len) returned <= returned + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_master_ui_sequencer.sv
// Directed bench for ahb_master_ui_sequencer with a queue-based reference model checked every cycle.
module tb_ahb_master_ui_sequencer;
  localparam int DW    = 32;
  localparam int BW    = 32;
  localparam int DEPTH = 16;

  logic          i_hclk = 1'b0;
  logic          i_hreset_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [31:0]   i_cmd_addr;
  logic [BW-1:0] i_cmd_len;
  logic [2:0]    i_cmd_size;
  logic          i_cmd_wr;
  logic [DW-1:0] i_wdata;
  logic          i_wdata_valid;
  logic          o_wdata_ready;
  logic          i_next;
  logic [DW-1:0] o_data;
  logic          o_dav;
  logic [31:0]   o_addr;
  logic [2:0]    o_size;
  logic          o_wr;
  logic          o_rd;
  logic [BW-1:0] o_min_len;
  logic          o_cont;
  logic [DW-1:0] i_rdata;
  logic          i_rdav;
  logic [DW-1:0] o_rdata;
  logic          o_rdata_valid;
  logic          o_busy;
  logic          o_done;

  ahb_master_ui_sequencer #(.DATA_WDT(DW), .BEAT_WDT(BW), .FIFO_DEPTH(DEPTH)) dut (
    .i_hclk(i_hclk), .i_hreset_n(i_hreset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(i_cmd_addr),
    .i_cmd_len(i_cmd_len), .i_cmd_size(i_cmd_size), .i_cmd_wr(i_cmd_wr),
    .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
    .i_next(i_next), .o_data(o_data), .o_dav(o_dav), .o_addr(o_addr), .o_size(o_size),
    .o_wr(o_wr), .o_rd(o_rd), .o_min_len(o_min_len), .o_cont(o_cont),
    .i_rdata(i_rdata), .i_rdav(i_rdav), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_hclk = ~i_hclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge i_hclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the sequencer owes the master, in beats and words.
  logic [31:0] q[$];
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_wr     = 1'b0;
  bit          m_rvld   = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_len    = '0;
  logic [31:0] m_issued = '0;
  logic [31:0] m_ret    = '0;
  logic [31:0] m_rdata  = '0;
  logic [2:0]  m_size   = '0;

  typedef struct packed {
    logic        cont;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] data;
  } beat_t;
  beat_t       beats[$];
  logic [31:0] rlog[$];
  int          gaps        = 0;
  int          done_cyc    = 0;
  int          last_rv_cyc = 0;

  always @(negedge i_hclk) begin : model_chk
    bit e_ui, e_wr, e_rd, e_dav, fire, acc, push, rtake, wr_fin, rd_fin;
    beat_t b;
    e_ui  = m_active && (m_issued != m_len);
    e_wr  = e_ui && m_wr;
    e_rd  = e_ui && !m_wr;
    e_dav = e_wr && (q.size() != 0);

    chk("cmd_ready", o_cmd_ready, !m_active && !m_done);
    chk("busy", o_busy, m_active);
    chk("done", o_done, m_done);
    chk("wr", o_wr, e_wr);
    chk("rd", o_rd, e_rd);
    chk("cont", o_cont, e_ui && (m_issued != 0));
    chk("dav", o_dav, e_dav);
    chk("wdata_ready", o_wdata_ready, q.size() < DEPTH);
    chk("rdata_valid", o_rdata_valid, m_rvld);
    if (m_rvld) chk("rdata", o_rdata, m_rdata);
    if (e_dav)  chk("data", o_data, q[0]);
    if (e_ui) begin
      chk("addr", o_addr, m_addr);
      chk("size", o_size, m_size);
      chk("min_len", o_min_len, m_len);
    end

    if (i_next && (o_rd || (o_wr && o_dav))) begin
      b.cont = o_cont; b.addr = o_addr; b.len = o_min_len; b.data = o_data;
      beats.push_back(b);
    end
    if (o_wr && o_cont && !o_dav) gaps++;
    if (o_rdata_valid) begin rlog.push_back(o_rdata); last_rv_cyc = cyc; end
    if (o_done) done_cyc = cyc;

    if (!i_hreset_n) begin
      q.delete();
      m_active = 0; m_done = 0; m_wr = 0; m_rvld = 0;
      m_addr = 0; m_len = 0; m_issued = 0; m_ret = 0; m_rdata = 0; m_size = 0;
    end else begin
      fire   = i_next && (e_rd || e_dav);
      acc    = i_cmd_valid && !m_active && !m_done;
      push   = i_wdata_valid && (q.size() < DEPTH);
      rtake  = m_active && !m_wr && i_rdav;
      wr_fin = fire && m_wr && (m_issued + 1 == m_len);
      rd_fin = m_active && !m_wr && (m_issued == m_len) && (m_ret == m_len);
      if (fire && m_wr) void'(q.pop_front());
      if (push) q.push_back(i_wdata);
      m_rvld = rtake;
      if (rtake) begin
        m_rdata = i_rdata;
        if (m_ret != m_len) m_ret = m_ret + 1;
      end
      if (fire) m_issued = m_issued + 1;
      m_done = wr_fin || rd_fin;
      if (wr_fin || rd_fin) m_active = 0;
      if (acc) begin
        m_addr = i_cmd_addr; m_len = i_cmd_len; m_size = i_cmd_size; m_wr = i_cmd_wr;
        m_issued = 0; m_ret = 0;
        m_active = (i_cmd_len != 0);
        m_done   = (i_cmd_len == 0);
      end
    end
  end

  task automatic tick();
    @(posedge i_hclk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      i_wdata_valid = 1'b1;
      i_wdata       = base + i;
      tick();
    end
    i_wdata_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size, input logic wr);
    i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_len = len; i_cmd_size = size; i_cmd_wr = wr;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!o_done && k < budget) begin tick(); k++; end
    chk(name, k < budget, 1'b1);
    tick();
  endtask

  task automatic chk_wbeats(input string name, input int n, input logic [31:0] addr, input logic [31:0] base);
    chk({name, "_count"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      chk({name, "_cont"}, beats[i].cont, i != 0);
      chk({name, "_len"}, beats[i].len, n);
      chk({name, "_bdata"}, beats[i].data, base + i);
      if (i == 0) chk({name, "_addr"}, beats[i].addr, addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    i_hreset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_size = '0;
    i_cmd_wr = 1'b0; i_wdata = '0; i_wdata_valid = 1'b0; i_next = 1'b0; i_rdata = '0; i_rdav = 1'b0;

    // 1: reset state
    repeat (3) tick();
    chk("t1_rd", o_rd, 0); chk("t1_wr", o_wr, 0); chk("t1_cont", o_cont, 0);
    chk("t1_done", o_done, 0); chk("t1_cmd_ready", o_cmd_ready, 1); chk("t1_wdata_ready", o_wdata_ready, 1);
    i_hreset_n = 1'b1;
    tick();

    // 2: preloaded 4-beat write
    push_words(32'h11, 4);
    beats.delete();
    i_next = 1'b1;
    send_cmd(32'h100, 4, 3'd2, 1'b1);
    wait_done("t2_done", 20);
    chk_wbeats("t2", 4, 32'h100, 32'h11);
    chk("t2_wr_after", o_wr, 0);

    // 3: underflow mid-burst gives three BUSY cycles
    push_words(32'h21, 2);
    beats.delete();
    gaps = 0;
    send_cmd(32'h200, 4, 3'd2, 1'b1);
    repeat (4) tick();
    i_wdata_valid = 1'b1; i_wdata = 32'h23;
    tick();
    i_wdata = 32'h24;
    tick();
    i_wdata_valid = 1'b0;
    wait_done("t3_done", 20);
    chk("t3_gaps", gaps, 3);
    chk_wbeats("t3", 4, 32'h200, 32'h21);

    // 4: i_next low for 5 cycles freezes the UI
    push_words(32'h31, 6);
    beats.delete();
    send_cmd(32'h300, 6, 3'd2, 1'b1);
    tick(); tick();
    i_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_hclk);
      chk("t4_wr", o_wr, 1); chk("t4_cont", o_cont, 1); chk("t4_addr", o_addr, 32'h300);
      chk("t4_dav", o_dav, 1); chk("t4_data", o_data, 32'h33);
      tick();
    end
    i_next = 1'b1;
    wait_done("t4_done", 20);
    chk_wbeats("t4", 6, 32'h300, 32'h31);

    // 5: 8-beat read, stray i_rdav while idle ignored
    rlog.delete();
    beats.delete();
    i_rdav = 1'b1; i_rdata = 32'hEE;
    tick();
    i_rdav = 1'b0;
    send_cmd(32'h400, 8, 3'd2, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      i_rdav = 1'b1; i_rdata = 32'hA0 + i;
      tick();
    end
    i_rdav = 1'b0;
    wait_done("t5_done", 20);
    chk("t5_rcount", rlog.size(), 8);
    for (int i = 0; i < 8 && i < rlog.size(); i++) chk("t5_rdata", rlog[i], 32'hA0 + i);
    chk("t5_done_gap", done_cyc - last_rv_cyc, 1);
    chk("t5_beats", beats.size(), 8);

    // 6a: zero-length command completes without a bus request
    beats.delete();
    send_cmd(32'h500, 0, 3'd2, 1'b1);
    chk("t6_len0_done", o_done, 1);
    tick();
    chk("t6_len0_done_off", o_done, 0);
    chk("t6_len0_ready", o_cmd_ready, 1);
    chk("t6_len0_beats", beats.size(), 0);

    // 6b: reset mid-burst aborts and flushes the FIFO
    push_words(32'h41, 4);
    send_cmd(32'h600, 8, 3'd2, 1'b1);
    tick(); tick();
    i_hreset_n = 1'b0;
    tick();
    i_hreset_n = 1'b1;
    chk("t6_rst_wr", o_wr, 0); chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_ready", o_cmd_ready, 1); chk("t6_rst_wready", o_wdata_ready, 1);
    beats.delete();
    send_cmd(32'h700, 1, 3'd2, 1'b1);
    chk("t6_req_wr", o_wr, 1); chk("t6_flushed_dav", o_dav, 0);
    tick();
    chk("t6_flushed_dav2", o_dav, 0);
    push_words(32'h55, 1);
    wait_done("t6_done", 20);
    chk_wbeats("t6", 1, 32'h700, 32'h55);

    // 7: FIFO full boundary, 17th word refused
    i_next = 1'b0;
    push_words(32'h60, 17);
    chk("t7_full", o_wdata_ready, 0);
    beats.delete();
    i_next = 1'b1;
    send_cmd(32'h800, 16, 3'd2, 1'b1);
    wait_done("t7_done", 40);
    chk_wbeats("t7", 16, 32'h800, 32'h60);
    chk("t7_empty_ready", o_wdata_ready, 1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
